// File: rtl/buy_success_actuator.sv
// Dispense/blink sequencer driven by the software "buy success" PIO bit.
// Optional piezo tone during LED-on phases when BUY_SUCCESS_BUZZER_EN is defined.
module buy_success_actuator #(
  parameter int DISPENSE_CYCLES   = 50000000,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int BLINK_COUNT       = 3,
  parameter int CNT_W             = 32
`ifdef BUY_SUCCESS_BUZZER_EN
  ,
  parameter int TONE_HALF_CYCLES  = 25000
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        buy_success,
  input  logic        abort,
  output logic        dispense,
  output logic        led,
  output logic        busy,
  output logic        done,
  output logic [15:0] vend_count
`ifdef BUY_SUCCESS_BUZZER_EN
  ,
  output logic        buzzer
`endif
);

  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);
  localparam int BLINK_W = $clog2(BLINK_COUNT + 2);
  localparam logic [BLINK_W-1:0] BLINK_TGT = BLINK_W'(BLINK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_DISPENSE, S_BLINK_ON, S_BLINK_OFF, S_WAIT_CLR
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   timer, timer_d;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_d, blink_inc;
  logic               normal_end;
  logic               dispense_d, led_d, busy_d;

  assign blink_inc = blink_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      blink_cnt <= blink_cnt_d;
    end
  end

  // Abort is only looked at once a vend is in progress, so a start in IDLE always wins.
  always_comb begin
    state_d    = state;
    normal_end = 1'b0;
    unique case (state)
      S_IDLE: if (buy_success) state_d = S_DISPENSE;
      S_DISPENSE: begin
        if (abort) state_d = S_WAIT_CLR;
        else if (timer == DISP_LAST) begin
          if (BLINK_COUNT > 0) state_d = S_BLINK_ON;
          else begin
            state_d    = S_WAIT_CLR;
            normal_end = 1'b1;
          end
        end
      end
      S_BLINK_ON: begin
        if (abort) state_d = S_WAIT_CLR;
        else if (timer == HALF_LAST) state_d = S_BLINK_OFF;
      end
      S_BLINK_OFF: begin
        if (abort) state_d = S_WAIT_CLR;
        else if (timer == HALF_LAST) begin
          if (blink_inc < BLINK_TGT) state_d = S_BLINK_ON;
          else begin
            state_d    = S_WAIT_CLR;
            normal_end = 1'b1;
          end
        end
      end
      S_WAIT_CLR: if (!abort && !buy_success) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d     = '0;
    blink_cnt_d = '0;
    if (state_d == state &&
        (state == S_DISPENSE || state == S_BLINK_ON || state == S_BLINK_OFF))
      timer_d = timer + 1'b1;
    // Blink tally survives ON/OFF alternation and is cleared everywhere else.
    if (state_d == S_BLINK_ON || state_d == S_BLINK_OFF)
      blink_cnt_d = (state == S_BLINK_OFF && state_d == S_BLINK_ON) ? blink_inc : blink_cnt;
    dispense_d = (state_d == S_DISPENSE);
    led_d      = (state_d == S_BLINK_ON);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dispense   <= 1'b0;
      led        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vend_count <= '0;
    end else begin
      dispense <= dispense_d;
      led      <= led_d;
      busy     <= busy_d;
      done     <= normal_end;
      if (normal_end) vend_count <= vend_count + 16'd1;
    end
  end

`ifdef BUY_SUCCESS_BUZZER_EN
  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF_CYCLES - 1);
  logic [CNT_W-1:0] tone_cnt;

  // Tone runs only while staying in BLINK_ON; entry or exit silences and restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (state_d != S_BLINK_ON || state != S_BLINK_ON) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      buzzer   <= ~buzzer;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end
`endif

endmodule
